// File: rtl/mul_unit.sv
// Pipelined integer multiplier covering MUL/MULH/MULHSU/MULHU.
// Stage 1 registers the extended operands, stage 2 multiplies, and later stages only retime.
module mul_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  logic              stall;
  logic [STAGES-1:0] valid_reg;
  logic [TAG_W-1:0]  tag_reg  [STAGES];
  logic [XLEN-1:0]   data_reg [1:STAGES-1];
  logic [XLEN:0]     a_reg;
  logic [XLEN:0]     b_reg;
  logic [1:0]        op_reg;

  logic              sign_a;
  logic              sign_b;
  logic [2*XLEN-1:0] a_wide;
  logic [2*XLEN-1:0] b_wide;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   product_sel;

  assign out_valid = valid_reg[STAGES-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  assign sign_a = rs1[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU));
  assign sign_b = rs2[XLEN-1] & (op == OP_MULH);

  // Sign-extending the XLEN+1 operands to 2*XLEN makes a plain modular multiply
  // equal to the signed product truncated to 2*XLEN bits.
  assign a_wide      = {{(XLEN-1){a_reg[XLEN]}}, a_reg};
  assign b_wide      = {{(XLEN-1){b_reg[XLEN]}}, b_reg};
  assign product     = a_wide * b_wide;
  assign product_sel = (op_reg == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else if (flush) begin
      valid_reg <= '0;
    end else if (!stall) begin
      valid_reg <= {valid_reg[STAGES-2:0], in_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      a_reg       <= {sign_a, rs1};
      b_reg       <= {sign_b, rs2};
      op_reg      <= op;
      tag_reg[0]  <= tag;
      tag_reg[1]  <= tag_reg[0];
      data_reg[1] <= product_sel;
    end
  end

  for (genvar gi = 2; gi < STAGES; gi++) begin : g_retime
    always_ff @(posedge clk) begin
      if (!stall) begin
        data_reg[gi] <= data_reg[gi-1];
        tag_reg[gi]  <= tag_reg[gi-1];
      end
    end
  end

  // Data registers are not reset, so the outputs are masked to read zero when idle.
  assign out_result = out_valid ? data_reg[STAGES-1] : '0;
  assign out_tag    = out_valid ? tag_reg[STAGES-1]  : '0;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed vectors, stall, flush, async reset
// and a randomized stream checked against a 64-bit arithmetic reference model.
module tb_mul_unit;
  localparam int XLEN   = 32;
  localparam int STAGES = 3;
  localparam int TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       op = '0;
  logic [XLEN-1:0]  rs1 = '0;
  logic [XLEN-1:0]  rs2 = '0;
  logic [TAG_W-1:0] tag = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  int cmp_count = 0;
  int mis_count = 0;

  logic             s_in_ready;
  logic             s_out_valid;
  logic [XLEN-1:0]  s_out_result;
  logic [TAG_W-1:0] s_out_tag;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t exp_q[$];

  mul_unit #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .rs1        (rs1),
    .rs2        (rs2),
    .tag        (tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the operands as the op interprets them.
  function automatic logic [31:0] ref_mul(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f_op)
      2'b00:   begin p = 64'(ua * ub); return p[31:0];  end
      2'b01:   begin p = 64'(sa * sb); return p[63:32]; end
      2'b10:   begin p = 64'(sa * ub); return p[63:32]; end
      default: begin p = 64'(ua * ub); return p[63:32]; end
    endcase
  endfunction

  // Sample outputs mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_in_ready   = in_ready;
    s_out_valid  = out_valid;
    s_out_result = out_result;
    s_out_tag    = out_tag;
    @(posedge clk);
    #1;
  endtask

  task automatic push_current();
    exp_t e;
    e.res = ref_mul(op, rs1, rs2);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic randomize_request(input logic [TAG_W-1:0] t);
    op  = 2'($urandom_range(0, 3));
    rs1 = $urandom;
    rs2 = $urandom;
    tag = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_count++;
    if (out_valid !== 1'b0) begin mis_count++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    cmp_count++;
    if (in_ready !== 1'b1) begin mis_count++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    cmp_count++;
    if (out_result !== '0) begin mis_count++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
    cmp_count++;
    if (out_tag !== '0) begin mis_count++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_directed();
    logic [1:0]       vop  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [XLEN-1:0]  va   [4] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [XLEN-1:0]  vb   [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [XLEN-1:0]  vexp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [TAG_W-1:0] vtag [4] = '{5'd3, 5'd9, 5'd17, 5'd30};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = vop[i]; rs1 = va[i]; rs2 = vb[i]; tag = vtag[i];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cmp_count++;
      if (s_in_ready !== 1'b1) begin mis_count++; $display("FAIL directed_in_ready[%0d]: got %b expected 1", i, s_in_ready); end
      lat = 1;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      cmp_count++;
      if (lat != STAGES) begin mis_count++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, STAGES); end
      cmp_count++;
      if (out_result !== vexp[i]) begin mis_count++; $display("FAIL directed_result[%0d]: got %h expected %h", i, out_result, vexp[i]); end
      cmp_count++;
      if (out_tag !== vtag[i]) begin mis_count++; $display("FAIL directed_tag[%0d]: got %0d expected %0d", i, out_tag, vtag[i]); end
      $display("directed op=%0d a=%h b=%h -> %h tag=%0d latency=%0d", vop[i], va[i], vb[i], out_result, out_tag, lat);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]      bop [4];
    logic [XLEN-1:0] ba  [4];
    logic [XLEN-1:0] bb  [4];
    logic [XLEN-1:0] frz_res;
    logic [TAG_W-1:0] frz_tag;
    bit frz = 0;
    int idx = 0;
    int held = 0;
    int retired = 0;
    int last_cyc = 0;
    int cyc = 0;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      bop[i] = 2'($urandom_range(0, 3)); ba[i] = $urandom; bb[i] = $urandom;
    end
    exp_q.delete();
    while (retired < 4 && cyc < 60) begin
      in_valid = (idx < 4);
      if (idx < 4) begin op = bop[idx]; rs1 = ba[idx]; rs2 = bb[idx]; tag = TAG_W'(idx); end
      out_ready = (held >= 5);
      tick();
      if (s_out_valid && !out_ready) begin
        cmp_count++;
        if (s_in_ready !== 1'b0) begin mis_count++; $display("FAIL b2b_in_ready_stall: got %b expected 0", s_in_ready); end
        if (frz) begin
          cmp_count++;
          if (s_out_result !== frz_res || s_out_tag !== frz_tag) begin
            mis_count++;
            $display("FAIL b2b_frozen: got %h/%0d expected %h/%0d", s_out_result, s_out_tag, frz_res, frz_tag);
          end
        end else begin
          frz = 1; frz_res = s_out_result; frz_tag = s_out_tag;
        end
        held++;
      end
      if (s_out_valid && out_ready) begin
        cmp_count++;
        if (exp_q.size() == 0) begin
          mis_count++; $display("FAIL b2b_unexpected: got tag %0d expected none", s_out_tag);
        end else begin
          e = exp_q.pop_front();
          if (s_out_result !== e.res || s_out_tag !== e.tag || s_out_tag !== TAG_W'(retired)) begin
            mis_count++;
            $display("FAIL b2b_retire[%0d]: got %h/%0d expected %h/%0d", retired, s_out_result, s_out_tag, e.res, e.tag);
          end
        end
        if (retired > 0) begin
          cmp_count++;
          if (cyc != last_cyc + 1) begin mis_count++; $display("FAIL b2b_consecutive: got cycle %0d expected %0d", cyc, last_cyc + 1); end
        end
        $display("b2b retire tag=%0d result=%h cycle=%0d", s_out_tag, s_out_result, cyc);
        last_cyc = cyc;
        retired++;
      end
      if (in_valid && s_in_ready) begin
        push_current();
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cmp_count++;
    if (retired != 4) begin mis_count++; $display("FAIL b2b_count: got %0d expected 4", retired); end
    cmp_count++;
    if (held != 5) begin mis_count++; $display("FAIL b2b_stall_cycles: got %0d expected 5", held); end
  endtask

  task automatic test_flush();
    int bad = 0;
    int lat;
    logic [XLEN-1:0] want;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_request(TAG_W'(i + 10));
      in_valid = 1'b1;
      tick();
      if (s_in_ready) push_current();
    end
    randomize_request(5'd20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    cmp_count++;
    if (!s_out_valid || exp_q.size() == 0 || s_out_tag !== exp_q[0].tag || s_out_result !== exp_q[0].res) begin
      mis_count++; $display("FAIL flush_cycle_retire: got valid=%b tag=%0d expected valid=1 tag=10", s_out_valid, s_out_tag);
    end
    $display("flush: retired tag=%0d during flush cycle", s_out_tag);
    exp_q.delete();
    for (int k = 0; k < STAGES; k++) begin
      tick();
      if (s_out_valid) bad++;
    end
    cmp_count++;
    if (bad != 0) begin mis_count++; $display("FAIL flush_quiet: got %0d valid cycles expected 0", bad); end
    randomize_request(5'd21);
    want = ref_mul(op, rs1, rs2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    cmp_count++;
    if (lat != STAGES || out_result !== want || out_tag !== 5'd21) begin
      mis_count++; $display("FAIL flush_after: got lat=%0d %h/%0d expected lat=%0d %h/21", lat, out_result, out_tag, STAGES, want);
    end
    $display("flush: post-flush op=%0d result=%h tag=%0d", op, out_result, out_tag);
    tick();
  endtask

  task automatic test_async_reset();
    int n = 0;
    int bad = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      randomize_request(TAG_W'(i + 1));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    cmp_count++;
    if (out_valid !== 1'b1) begin mis_count++; $display("FAIL areset_pre_valid: got %b expected 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    cmp_count++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0) begin
      mis_count++; $display("FAIL areset_drop: got valid=%b %h/%0d expected 0 0/0", out_valid, out_result, out_tag);
    end
    cmp_count++;
    if (in_ready !== 1'b1) begin mis_count++; $display("FAIL areset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) begin
      tick();
      if (s_out_valid) bad++;
    end
    cmp_count++;
    if (bad != 0) begin mis_count++; $display("FAIL areset_ghost: got %0d valid cycles expected 0", bad); end
    $display("async reset: in-flight requests dropped");
  endtask

  task automatic test_random();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit prev_stall = 0;
    logic [XLEN-1:0] prev_res;
    logic [TAG_W-1:0] prev_tag;
    exp_t e;
    exp_q.delete();
    while ((sent < 10000 || exp_q.size() != 0) && cyc < 40000) begin
      in_valid = (sent < 10000) && ($urandom_range(0, 4) != 0);
      randomize_request(TAG_W'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      cmp_count++;
      if (s_in_ready !== !(s_out_valid && !out_ready)) begin
        mis_count++; $display("FAIL rand_in_ready: got %b expected %b", s_in_ready, !(s_out_valid && !out_ready));
      end
      if (prev_stall) begin
        cmp_count++;
        if (!s_out_valid || s_out_result !== prev_res || s_out_tag !== prev_tag) begin
          mis_count++; $display("FAIL rand_stable: got %h/%0d expected %h/%0d", s_out_result, s_out_tag, prev_res, prev_tag);
        end
      end
      prev_stall = s_out_valid && !out_ready;
      prev_res = s_out_result;
      prev_tag = s_out_tag;
      if (s_out_valid && out_ready) begin
        cmp_count++;
        if (exp_q.size() == 0) begin
          mis_count++; $display("FAIL rand_unexpected: got %h/%0d expected none", s_out_result, s_out_tag);
        end else begin
          e = exp_q.pop_front();
          if (s_out_result !== e.res || s_out_tag !== e.tag) begin
            mis_count++; $display("FAIL rand_retire[%0d]: got %h/%0d expected %h/%0d", got, s_out_result, s_out_tag, e.res, e.tag);
          end
          $display("rand #%0d tag=%0d result=%h", got, s_out_tag, s_out_result);
        end
        got++;
      end
      if (in_valid && s_in_ready) begin
        push_current();
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    cmp_count++;
    if (sent != 10000 || exp_q.size() != 0 || got != 10000) begin
      mis_count++; $display("FAIL rand_drain: got sent=%0d retired=%0d pending=%0d expected 10000/10000/0", sent, got, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mis_count);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Parameters
REQ-001 XLEN, default 32: operand and result width; legal values 8..64.
REQ-002 STAGES, default 3: input-accept to result latency in cycles; legal values 2..6.
REQ-003 TAG_W, default 5: width of the sideband tag (destination register id).

Interface
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  unit can accept a request this cycle.
REQ-008 op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-009 rs1  in  XLEN  first operand (signed for MULH/MULHSU).
REQ-010 rs2  in  XLEN  second operand (signed for MULH only).
REQ-011 tag  in  TAG_W  sideband carried with the request.
REQ-012 flush  in  1  discard every in-flight request.
REQ-013 out_valid  out  1  result present.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_result  out  XLEN  selected product half.
REQ-016 out_tag  out  TAG_W  tag of the request that produced out_result.

Function
REQ-017 Accept occurs when in_valid && in_ready at a rising edge; retire occurs when out_valid && out_ready.
REQ-018 The pipeline SHALL have STAGES register stages; each stage holds valid, op, tag and data.
REQ-019 Stall = out_valid && !out_ready; during stall every stage holds its contents, and in_ready = !stall (combinational).
REQ-020 With no stall, a request accepted at edge N SHALL present out_valid at edge N+STAGES-1 (visible after that edge), i.e. latency exactly STAGES cycles; throughput one request per cycle.
REQ-021 Operands SHALL be extended to XLEN+1 bits: rs1 sign-extended for MULH/MULHSU, else zero-extended; rs2 sign-extended for MULH only, else zero-extended; the signed (XLEN+1)x(XLEN+1) product is truncated to 2*XLEN bits.
REQ-022 out_result SHALL be product[XLEN-1:0] for MUL and product[2*XLEN-1:XLEN] for MULH/MULHSU/MULHU.
REQ-023 The multiply SHALL be performed in stage 2; stage 1 registers extended operands; any stages beyond 2 are pure retiming registers.
REQ-024 Requests SHALL retire in acceptance order; out_tag SHALL match the tag captured with that request.
REQ-025 While out_valid is high and out_ready low, out_result and out_tag SHALL remain stable.
REQ-026 flush SHALL clear every stage valid bit at the next edge, overriding stall; a request presented in the flush cycle SHALL be discarded; in_ready is unaffected by flush.
REQ-027 A result retiring in the flush cycle (out_valid && out_ready) counts as delivered.
REQ-028 Bubbles (invalid stages) SHALL not be compressed; stall freezes the whole pipe regardless of bubbles.

Reset
REQ-029 rst_n low SHALL immediately clear all stage valid bits, forcing out_valid=0; in_ready=1 while in reset.
REQ-030 out_result and out_tag SHALL read 0 in reset; data registers need not otherwise be reset.
REQ-031 Reset asserted mid-operation SHALL drop all in-flight requests; none emerges after release.
REQ-032 First accept is permitted at the first rising edge with rst_n high.

Verification
REQ-033 XLEN=32, STAGES=3: MUL 7 x 0xFFFFFFFD, tag 3 -> out_valid 3 cycles later, out_result 0xFFFFFFEB, out_tag 3.
REQ-034 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 Back-to-back 4 requests, tags 0..3, out_ready held low 5 cycles after first out_valid -> in_ready low during stall, results frozen, then tags 0,1,2,3 retire in 4 consecutive cycles.
REQ-036 3 requests in flight, flush pulsed for 1 cycle concurrent with a new request -> out_valid stays 0 for the next STAGES cycles; subsequent request completes normally.
REQ-037 rst_n asserted asynchronously between edges with 2 requests in flight -> out_valid falls without a clock edge; no result emerges after release.
REQ-038 Random op/operand stream (10k requests) with random out_ready against a 64-bit reference model -> every result and tag matches, order preserved.
